bin_mult_ram_fetch: RTL and testbench
=====================================

Name: bin_mult_ram_fetch

Overview:
- Wishbone master on the shared OpenRAM rambus that sits directly upstream of the binary-multiplier core.
- On a start command it reads a block of consecutive 32-bit operand words from shared RAM, buffers them in a small FIFO, and presents them to the multiplier on a valid/ready stream.
- It replaces CPU-driven operand loading through the Caravel slave port.

Parameters:
- FIFO_DEPTH, 4, operand FIFO entries; must be a power of 2, 2..16.
- LEN_W, 10, width of the transfer length field; maximum 1023 words.
- TIMEOUT, 255, cycles to wait for rambus ack before aborting; minimum 1.

Ports:
- wb_clk_i  in  1  system clock; also forwarded on rambus_wb_clk_o.
- wb_rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle pulse that begins a transfer; ignored while busy_o=1.
- abort_i  in  1  stops the transfer cleanly (see Behaviour).
- base_adr_i  in  10  first RAM word address; sampled on start.
- len_i  in  LEN_W  number of words to read; sampled on start.
- busy_o  out  1  transfer in progress.
- done_o  out  1  transfer finished; level, cleared by the next accepted start.
- err_o  out  1  ack timeout occurred; sticky until the next accepted start.
- rambus_wb_clk_o  out  1  equals wb_clk_i.
- rambus_wb_rst_o  out  1  equals wb_rst_i.
- rambus_wb_cyc_o  out  1  bus cycle.
- rambus_wb_stb_o  out  1  strobe; always equal to cyc.
- rambus_wb_we_o  out  1  constant 0.
- rambus_wb_sel_o  out  4  constant 4'hF.
- rambus_wb_adr_o  out  10  word address.
- rambus_wb_dat_o  out  32  constant 0.
- rambus_wb_ack_i  in  1  ack.
- rambus_wb_dat_i  in  32  read data; valid when ack=1.
- op_data_o  out  32  operand to the multiplier (FIFO head).
- op_valid_o  out  1  FIFO not empty.
- op_ready_i  in  1  multiplier accepts; pop occurs when valid&ready.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - State IDLE.
  - cyc/stb/busy/done/err = 0; adr = 0.
  - FIFO empty, so op_valid_o = 0.
- State machine: IDLE, ISSUE, REQ, DONE.
- IDLE:
  - On start_i: latch adr <= base_adr_i and rem <= len_i; clear done/err; set busy=1.
  - If len_i == 0: go to DONE next cycle with no bus activity.
  - Otherwise go to ISSUE.
- ISSUE: cyc/stb = 0. If FIFO is not full (counting the pop in the same cycle), go to REQ; otherwise wait.
- REQ:
  - cyc = stb = 1 and rambus_wb_adr_o = adr, all driven from registers.
  - On ack: push rambus_wb_dat_i into the FIFO in the same cycle; adr <= adr+1 (mod 1024, so 1023 wraps to 0); rem <= rem-1; drop cyc/stb next cycle.
  - If rem was 1, go to DONE; else go to ISSUE.
  - Consequence: cyc/stb are low for at least 1 cycle between transfers. Best-case throughput is 1 word per 3 cycles with a single-cycle-latency ack.
- Timeout: a counter runs while in REQ. If TIMEOUT cycles pass without ack: drop cyc/stb, set err=1, go to DONE. A late ack arriving outside REQ is ignored and never pushed.
- DONE: busy = 0, done = 1. Return to IDLE in the same cycle (done stays high). A start may be accepted from the following cycle.
- abort_i:
  - In ISSUE: go to DONE.
  - In REQ: finish the current beat (ack or timeout), then go to DONE.
  - In IDLE: no effect.
  - Words already in the FIFO remain poppable.
- The FIFO is not flushed by start or abort; the downstream consumer drains it. Only reset empties it.
- Simultaneous push and pop on a full FIFO: never occurs, because a request is only issued when a slot is guaranteed free.
- Simultaneous push and pop on an empty FIFO: the push is written; op_valid_o rises next cycle. There is no bypass, so FIFO latency is 1 cycle.
- start_i while busy: ignored, with no state change.

Decomposition:
- Shared package bin_mult_pkg holds:
  - the state enum (IDLE/ISSUE/REQ/DONE);
  - RAMBUS_ADR_W = 10;
  - WORD_W = 32;
  - SEL_ALL = 4'hF.
- One sub-module, bin_mult_sync_fifo (WIDTH, DEPTH):
  - push/pop interface with full, empty and count outputs;
  - async active-high reset;
  - pointers wrap modulo DEPTH.

Test Plan:
- Reset mid-transfer (assert wb_rst_i while in REQ) -> cyc/stb/busy/done/err and op_valid_o all 0 immediately, without waiting for a clock edge.
- base=0x010, len=3, RAM returns 0xA0000010..12, 1-cycle ack, op_ready=1 -> 3 reads at adr 0x010, 0x011, 0x012 with a cyc gap between each; op_data sequence A0000010, A0000011, A0000012; done=1, err=0.
- base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- len=0 -> no cyc assertion; done=1 two cycles after start; busy high for exactly 1 cycle.
- op_ready=0, len=8, FIFO_DEPTH=4 -> exactly 4 reads, then the block waits in ISSUE with cyc=0. Raising op_ready -> remaining 4 reads complete, 8 words delivered in order.
- Ack held low, TIMEOUT=255 -> cyc drops after 255 cycles; err=1, done=1, no FIFO push. A late ack is ignored. The next start clears err.

Source files
------------

// File: rtl/bin_mult_pkg.sv
// Shared types and constants for the binary-multiplier operand fetch path.
package bin_mult_pkg;

  localparam int RAMBUS_ADR_W = 10;
  localparam int WORD_W       = 32;
  localparam logic [3:0] SEL_ALL = 4'hF;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_REQ   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bin_mult_sync_fifo.sv
// Small synchronous FIFO with registered occupancy. There is no bypass path:
// a word pushed into an empty FIFO becomes visible on the following cycle.
module bin_mult_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pushes into a full FIFO and pops from an empty one are dropped.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Next occupancy from the push/pop combination.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bin_mult_ram_fetch.sv
// Wishbone read master that fetches a block of operand words from the shared
// RAM bus and streams them to the multiplier through a small FIFO.
//
// Operand stream handshake: op_valid_o is high whenever the FIFO holds a word
// and op_data_o is that word; a transfer happens on every cycle where
// op_valid_o && op_ready_i, and op_data_o is only meaningful while valid.
module bin_mult_ram_fetch
  import bin_mult_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [RAMBUS_ADR_W-1:0] base_adr_i,
  input  logic [LEN_W-1:0]        len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    rambus_wb_clk_o,
  output logic                    rambus_wb_rst_o,
  output logic                    rambus_wb_cyc_o,
  output logic                    rambus_wb_stb_o,
  output logic                    rambus_wb_we_o,
  output logic [3:0]              rambus_wb_sel_o,
  output logic [RAMBUS_ADR_W-1:0] rambus_wb_adr_o,
  output logic [WORD_W-1:0]       rambus_wb_dat_o,
  input  logic                    rambus_wb_ack_i,
  input  logic [WORD_W-1:0]       rambus_wb_dat_i,
  output logic [WORD_W-1:0]       op_data_o,
  output logic                    op_valid_o,
  input  logic                    op_ready_i
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                  state_q;
  logic [RAMBUS_ADR_W-1:0] adr_q;
  logic [LEN_W-1:0]        rem_q;
  logic [TW-1:0]           tmo_q;
  logic                    cyc_q, busy_q, done_q, err_q, abort_pend_q;

  logic                    push, pop, fifo_full, fifo_empty, fifo_room;
  logic [CW-1:0]           fifo_level_unused;

  // Only an ack seen while a request is outstanding carries data; late acks
  // after a timeout are ignored.
  assign push = (state_q == ST_REQ) && rambus_wb_ack_i;
  assign pop  = op_valid_o && op_ready_i;
  // A slot freed by this cycle's pop counts as room for the next request.
  assign fifo_room = !fifo_full || pop;

  bin_mult_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push),
    .din_i   (rambus_wb_dat_i),
    .pop_i   (pop),
    .dout_o  (op_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_level_unused)
  );

  assign op_valid_o      = !fifo_empty;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = wb_rst_i;
  assign rambus_wb_cyc_o = cyc_q;
  assign rambus_wb_stb_o = cyc_q;
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = SEL_ALL;
  assign rambus_wb_adr_o = adr_q;
  assign rambus_wb_dat_o = '0;

  // Fetch sequencer: one request per ISSUE/REQ pair, so cyc always has a gap
  // between beats; all bus outputs come straight from these registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      adr_q        <= '0;
      rem_q        <= '0;
      tmo_q        <= '0;
      cyc_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            adr_q        <= base_adr_i;
            rem_q        <= len_i;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= (len_i == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort_i) begin
            state_q <= ST_DONE;
          end else if (fifo_room) begin
            cyc_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rambus_wb_ack_i) begin
            cyc_q        <= 1'b0;
            adr_q        <= adr_q + RAMBUS_ADR_W'(1);
            rem_q        <= rem_q - LEN_W'(1);
            abort_pend_q <= 1'b0;
            state_q      <= (rem_q == LEN_W'(1) || abort_pend_q || abort_i)
                            ? ST_DONE : ST_ISSUE;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            cyc_q        <= 1'b0;
            err_q        <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= ST_DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
            if (abort_i) abort_pend_q <= 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_mult_ram_fetch.sv
// Directed bench for the operand fetch master with a behavioural RAM slave
// that acks one cycle after a request is seen.
module tb_bin_mult_ram_fetch;

  logic        clk;
  logic        rst;
  logic        start, abort;
  logic [9:0]  base;
  logic [9:0]  len;
  logic        busy, done, err;
  logic        r_clk, r_rst, cyc, stb, we;
  logic [3:0]  sel;
  logic [9:0]  adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] op_data;
  logic        op_valid, op_ready;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] ram [1024];
  logic [31:0] exp_q[$];
  logic [31:0] obs_data_q[$];
  logic [9:0]  obs_adr_q[$];
  int          cyc_rises = 0;
  logic        cyc_prev = 1'b0;
  int          lat = 0;
  bit          ack_en = 1'b0;
  bit          late_req = 1'b0;

  bin_mult_ram_fetch dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .start_i         (start),
    .abort_i         (abort),
    .base_adr_i      (base),
    .len_i           (len),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .rambus_wb_clk_o (r_clk),
    .rambus_wb_rst_o (r_rst),
    .rambus_wb_cyc_o (cyc),
    .rambus_wb_stb_o (stb),
    .rambus_wb_we_o  (we),
    .rambus_wb_sel_o (sel),
    .rambus_wb_adr_o (adr),
    .rambus_wb_dat_o (wdat),
    .rambus_wb_ack_i (ack),
    .rambus_wb_dat_i (rdat),
    .op_data_o       (op_data),
    .op_valid_o      (op_valid),
    .op_ready_i      (op_ready)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM slave and stream monitor, evaluated away from the DUT's active edge.
  always @(negedge clk) begin
    if (cyc && !cyc_prev) cyc_rises++;
    cyc_prev = cyc;
    if (op_valid && op_ready) obs_data_q.push_back(op_data);
    if (ack) begin
      ack = 1'b0;
    end else if (late_req) begin
      ack      = 1'b1;
      rdat     = 32'hDEAD_BEEF;
      late_req = 1'b0;
    end else if (cyc && ack_en) begin
      if (lat == 1) begin
        ack  = 1'b1;
        rdat = ram[adr];
        obs_adr_q.push_back(adr);
        lat  = 0;
      end else begin
        lat++;
      end
    end else begin
      lat = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_xfer(input logic [9:0] b, input logic [9:0] l);
    tick();
    base  = b;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!(done && !busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, done && !busy}, 32'd1);
  endtask

  task automatic expect_words(input logic [9:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [9:0] a;
      a = b + 10'(i);
      exp_q.push_back(32'hA000_0000 + {22'd0, a});
    end
  endtask

  task automatic check_adrs(input string tag, input logic [9:0] b, input int n);
    check({tag, "_nreads"}, obs_adr_q.size(), n);
    for (int i = 0; i < obs_adr_q.size() && i < n; i++) begin
      logic [9:0] a;
      a = b + 10'(i);
      check({tag, "_adr"}, {22'd0, obs_adr_q[i]}, {22'd0, a});
    end
    obs_adr_q.delete();
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_nwords"}, obs_data_q.size(), exp_q.size());
    while (obs_data_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, obs_data_q.pop_front(), exp_q.pop_front());
    obs_data_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int r0;
    int hi;
    int t;
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 + i;
    ack      = 1'b0;
    rdat     = '0;
    start    = 1'b0;
    abort    = 1'b0;
    base     = '0;
    len      = '0;
    op_ready = 1'b0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_cyc", {31'd0, cyc}, 32'd0);
    check("rst_adr", {22'd0, adr}, 32'd0);
    check("rst_valid", {31'd0, op_valid}, 32'd0);
    check("const_sel", {28'd0, sel}, 32'hF);
    check("const_we", {31'd0, we}, 32'd0);
    tick();
    rst = 1'b0;

    // Reset asserted mid-request clears outputs without a clock edge
    ack_en = 1'b0;
    start_xfer(10'h005, 10'd2);
    t = 0;
    while (!cyc && t < 20) begin @(negedge clk); t++; end
    check("midrst_reached_req", {31'd0, cyc}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_cyc", {31'd0, cyc}, 32'd0);
    check("midrst_stb", {31'd0, stb}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_valid", {31'd0, op_valid}, 32'd0);
    tick();
    rst = 1'b0;
    obs_adr_q.delete();
    obs_data_q.delete();

    // Basic 3-word block
    ack_en = 1'b1;
    op_ready = 1'b1;
    r0 = cyc_rises;
    expect_words(10'h010, 3);
    start_xfer(10'h010, 10'd3);
    wait_done("t2_done", 100);
    check("t2_err", {31'd0, err}, 32'd0);
    repeat (5) @(negedge clk);
    check("t2_cyc_gaps", cyc_rises - r0, 3);
    check_adrs("t2", 10'h010, 3);
    check_stream("t2");

    // Address wrap at the top of RAM
    expect_words(10'h3FE, 4);
    start_xfer(10'h3FE, 10'd4);
    wait_done("t3_done", 100);
    repeat (5) @(negedge clk);
    check_adrs("t3", 10'h3FE, 4);
    check_stream("t3");

    // Zero-length transfer
    r0 = cyc_rises;
    start_xfer(10'h020, 10'd0);
    check("t4_busy_first", {31'd0, busy}, 32'd1);
    check("t4_done_first", {31'd0, done}, 32'd0);
    tick();
    check("t4_busy_second", {31'd0, busy}, 32'd0);
    check("t4_done_second", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
    check("t4_no_cyc", cyc_rises - r0, 0);

    // Backpressure: FIFO fills, block parks in ISSUE
    op_ready = 1'b0;
    expect_words(10'h100, 8);
    start_xfer(10'h100, 10'd8);
    repeat (40) @(negedge clk);
    check("t5_reads_full", obs_adr_q.size(), 4);
    check("t5_cyc_parked", {31'd0, cyc}, 32'd0);
    check("t5_busy_parked", {31'd0, busy}, 32'd1);
    check("t5_valid_parked", {31'd0, op_valid}, 32'd1);
    tick();
    op_ready = 1'b1;
    wait_done("t5_done", 200);
    repeat (5) @(negedge clk);
    check_adrs("t5", 10'h100, 8);
    check_stream("t5");

    // Ack timeout
    tick();
    ack_en = 1'b0;
    start_xfer(10'h050, 10'd2);
    t = 0;
    while (!cyc && t < 20) begin @(negedge clk); t++; end
    hi = 0;
    while (cyc && hi < 400) begin hi++; @(negedge clk); end
    check("t6_cyc_high_cycles", hi, 255);
    wait_done("t6_done", 20);
    check("t6_err", {31'd0, err}, 32'd1);
    check("t6_no_push", {31'd0, op_valid}, 32'd0);
    tick();
    late_req = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_late_ack_valid", {31'd0, op_valid}, 32'd0);
    check("t6_late_ack_words", obs_data_q.size(), 0);
    check("t6_err_sticky", {31'd0, err}, 32'd1);
    tick();
    ack_en = 1'b1;
    expect_words(10'h010, 1);
    start_xfer(10'h010, 10'd1);
    check("t6_err_cleared", {31'd0, err}, 32'd0);
    wait_done("t6_retry_done", 100);
    repeat (5) @(negedge clk);
    check("t6_retry_err", {31'd0, err}, 32'd0);
    obs_adr_q.delete();
    check_stream("t6_retry");

    // Abort while parked in ISSUE keeps buffered words
    op_ready = 1'b0;
    expect_words(10'h200, 4);
    start_xfer(10'h200, 10'd6);
    repeat (30) @(negedge clk);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("t7_done", 20);
    check("t7_err", {31'd0, err}, 32'd0);
    check("t7_valid_kept", {31'd0, op_valid}, 32'd1);
    repeat (5) @(negedge clk);
    check_adrs("t7", 10'h200, 4);
    tick();
    op_ready = 1'b1;
    repeat (8) @(negedge clk);
    check_stream("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
